indication_pipe_arbiter: RTL and testbench
==========================================

# indication_pipe_arbiter

Round-robin arbiter that shares one outbound indication pipe among several indication-output sources. Each source enqueues a complete message word of `{v, meth, tag}` fields into a private one-entry holding slot. The arbiter drains the occupied slots onto the single `pipe$enq` port in fair rotating order and tags each beat with its source index. It sits between the per-interface indication-output serializers and the transport pipe.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 96: message width, `32 + (32 + 32)` for `{v, meth, tag}`.
- `SRCW`, default 2: source-index width, equal to clog2(`NREQ`).

Ports:
- `CLK`, input, 1: clock, rising edge.
- `nRST`, input, 1: reset, asynchronous, active-low.
- `in$enq__ENA`, input, `NREQ`: per-source enqueue strobe.
- `in$enq$v`, input, `NREQ*WIDTH`: per-source message; source i occupies bits [i*WIDTH +: WIDTH].
- `in$enq__RDY`, output, `NREQ`: per-source slot free.
- `pipe$enq__ENA`, output, 1: outbound beat.
- `pipe$enq$v`, output, `WIDTH`: outbound message.
- `pipe$enq$src`, output, `SRCW`: index of the source being forwarded.
- `pipe$enq__RDY`, input, 1: pipe can accept.
- `stat$clear`, input, 1: clear statistics (only with `INDARB_STATS_EN`).
- `stat$count`, output, `NREQ*16`: per-source forwarded-beat counters (only with `INDARB_STATS_EN`).

## Operation
State:
- `valid[NREQ]`: slot-occupied bits.
- `slot[i]`: one `WIDTH`-bit register per source.
- `ptr`: `SRCW`-bit round-robin pointer.

Enqueue:
- `in$enq__RDY[i] = !valid[i]`, forced to 0 while `nRST` is low.
- When `in$enq__ENA[i] & in$enq__RDY[i]`: `slot[i] <= in$enq$v[i]` and `valid[i] <= 1`.
- ENA without RDY is a source protocol error. It is ignored: no state change.

Arbitration (combinational):
- `grant` is the first i with `valid[i]` set, scanning `ptr`, `ptr+1`, … mod `NREQ`.
- `pipe$enq__ENA = (|valid) & pipe$enq__RDY`.
- `pipe$enq$v = slot[grant]` and `pipe$enq$src = grant` whenever any slot is valid. Both are 0 when no slot is valid.

Drain (when `pipe$enq__ENA` is 1):
- `valid[grant] <= 0`.
- `ptr <= (grant + 1) mod NREQ`. The wrap from `NREQ-1` goes to 0.
- When `pipe$enq__ENA` is 0, `ptr` holds.

Message contents pass through unmodified; the block never inspects the tag, meth or v fields.

## Timing
- Latency: a message accepted at edge T is eligible for output in the cycle after T. It appears at the earliest in the cycle after T if it wins arbitration and `pipe$enq__RDY` is 1.
- No bypass: a slot cannot be refilled in the same cycle it drains. `in$enq__RDY[i]` rises the cycle after its drain. The maximum rate per source is therefore 1 beat every 2 cycles. Aggregate output reaches 1 beat per cycle with 2 or more active sources.
- Enqueue and drain of different sources in the same cycle are independent and both take effect.
- Fairness: with all sources continuously full, the grant order is ptr, ptr+1, …. The worst-case wait for a valid slot is `NREQ-1` beats.
- `pipe$enq__RDY` low stalls the output. `grant`, `ptr` and all slots hold, and the output data stays stable.
- Reset values:
  - `valid`, `ptr`, all slots and the counters are 0.
  - `pipe$enq__ENA` is 0, `pipe$enq$v` is 0, `pipe$enq$src` is 0, `in$enq__RDY` is 0.
  - One cycle after `nRST` deasserts, `in$enq__RDY` is all-ones.
- Reset mid-operation discards all buffered messages immediately. Nothing is emitted for them.

## Configuration
- Macro `INDARB_STATS_EN`.
- Defined:
  - One 16-bit counter per source, incremented when that source drains.
  - Counters wrap from 0xFFFF to 0.
  - `stat$clear` zeroes all counters synchronously. If a drain happens in the same cycle as the clear, the clear wins.
  - `stat$count[i*16 +: 16]` shows counter i.
- Undefined: `stat$clear` and `stat$count` are absent and no counter logic is built. Forwarding behaviour is identical in both configurations.

## Test plan
All scenarios use `NREQ=4`, `WIDTH=96`.
1. **Reset:** hold `nRST` low mid-traffic with 3 slots full. Required: `pipe$enq__ENA` = 0 and `in$enq__RDY` = 0 immediately. After release, `in$enq__RDY` = 4'b1111 and no stale beat is emitted.
2. **Single source:** `pipe$enq__RDY` held 1; source 2 enqueues {v=0x55, meth=7, tag=1} at edge T. Required: the output beat in the cycle after T has `pipe$enq$v` = {0x55, 7, 1} and `src` = 2. `in$enq__RDY[2]` returns to 1 the cycle after the beat.
3. **Round robin:** all 4 slots filled in one cycle with `ptr` = 0. Required: sources come out as 0, 1, 2, 3 on consecutive cycles. Refill all 4 with `ptr` = 0 again: order is 0, 1, 2, 3. Fill only 1 and 3 with `ptr` = 2: order is 3 then 1.
4. **Backpressure:** slots 0 and 1 full, `pipe$enq__RDY` = 0 for 5 cycles. Required: ENA = 0 and data stable showing source 0. On release the beats are 0 then 1, with no loss or duplication.
5. **Refill and concurrency:** source 0 enqueues on every cycle that `in$enq__RDY[0]` is 1, while source 1 is enqueued in the same cycle that source 0 drains. Required: both messages are forwarded, source 0 sustains 1 beat per 2 cycles, and the output is gap-free.
6. **Statistics (`INDARB_STATS_EN`):** preload 0xFFFE via 0xFFFE drains of source 3 (or force the counter), then drain 2 more. Required: counter 3 reads 0xFFFF, then 0x0000. Asserting `stat$clear` in a drain cycle leaves the counter at 0.

Source files
------------

// File: rtl/indication_pipe_arbiter.sv
// rtl/indication_pipe_arbiter.sv - round-robin arbiter sharing one indication pipe among NREQ sources
//
// Purpose:
//   Each source owns a one-entry holding slot. Occupied slots are drained onto
//   the single outbound pipe in rotating order, one beat per cycle, and every
//   beat carries the index of the source it came from. Message words are passed
//   through untouched.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   in_enq_ena/_v        per-source enqueue strobe and message (source i at [i*WIDTH +: WIDTH])
//   in_enq_rdy           per-source slot free (0 while in reset)
//   pipe_enq_ena/_v      outbound beat strobe and message
//   pipe_enq_src         source index of the outbound message
//   pipe_enq_rdy         outbound pipe can accept
//   stat_clear           synchronous clear of the per-source beat counters
//   stat_count           per-source forwarded-beat counters, 16 bits each
//
// Optional feature macro: INDARB_STATS_EN adds stat_clear / stat_count and the
// counters behind them; without it those ports and the counters do not exist.

module indication_pipe_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 96,
  parameter int SRCW  = 2
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       in_enq_ena,
  input  logic [NREQ*WIDTH-1:0] in_enq_v,
  output logic [NREQ-1:0]       in_enq_rdy,
  output logic                  pipe_enq_ena,
  output logic [WIDTH-1:0]      pipe_enq_v,
  output logic [SRCW-1:0]       pipe_enq_src,
  input  logic                  pipe_enq_rdy
`ifdef INDARB_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [NREQ*16-1:0]    stat_count
`endif
);

  logic [NREQ-1:0]  valid_q, valid_d;
  logic [WIDTH-1:0] slot_q [NREQ];
  logic [SRCW-1:0]  ptr_q, ptr_d;
  logic [SRCW-1:0]  grant;
  logic [SRCW-1:0]  scan_idx;
  logic             found;
  logic             any_valid;
  logic             fire;
  logic [NREQ-1:0]  enq_acc;

  assign any_valid = |valid_q;
  assign fire      = any_valid & pipe_enq_rdy;

  // ENA on an occupied slot is a source protocol error and is simply dropped.
  assign enq_acc    = in_enq_ena & ~valid_q;
  assign in_enq_rdy = nRST ? ~valid_q : '0;

  // First occupied slot at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = SRCW'((int'(ptr_q) + k) % NREQ);
      if (!found && valid_q[scan_idx]) begin
        found = 1'b1;
        grant = scan_idx;
      end
    end
  end

  assign pipe_enq_ena = fire;
  assign pipe_enq_v   = any_valid ? slot_q[grant] : '0;
  assign pipe_enq_src = any_valid ? grant : '0;

  // A draining slot is never the one being refilled (its RDY is low), so the
  // set and clear below never collide on the same bit.
  always_comb begin
    valid_d = valid_q | enq_acc;
    ptr_d   = ptr_q;
    if (fire) begin
      valid_d[grant] = 1'b0;
      ptr_d          = (grant == SRCW'(NREQ - 1)) ? '0 : grant + SRCW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < NREQ; i++) begin
        if (enq_acc[i]) begin
          slot_q[i] <= in_enq_v[i*WIDTH +: WIDTH];
        end
      end
    end
  end

`ifdef INDARB_STATS_EN
  logic [15:0] cnt_q [NREQ];

  // Clear takes priority over a same-cycle drain; counters wrap naturally.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (stat_clear) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (fire) begin
      cnt_q[grant] <= cnt_q[grant] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
    assign stat_count[gi*16 +: 16] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_indication_pipe_arbiter.sv
// tb/tb_indication_pipe_arbiter.sv - self-checking bench for indication_pipe_arbiter

module tb_indication_pipe_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 96;
  localparam int SRCW  = 2;

  logic                  CLK = 1'b0;
  logic                  nRST;
  logic [NREQ-1:0]       in_ena;
  logic [NREQ*WIDTH-1:0] in_v;
  logic [NREQ-1:0]       in_rdy;
  logic                  p_ena;
  logic [WIDTH-1:0]      p_v;
  logic [SRCW-1:0]       p_src;
  logic                  p_rdy;
`ifdef INDARB_STATS_EN
  logic                  st_clear;
  logic [NREQ*16-1:0]    st_count;
`endif

  always #5 CLK = ~CLK;

  indication_pipe_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SRCW(SRCW)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_enq_ena   (in_ena),
    .in_enq_v     (in_v),
    .in_enq_rdy   (in_rdy),
    .pipe_enq_ena (p_ena),
    .pipe_enq_v   (p_v),
    .pipe_enq_src (p_src),
    .pipe_enq_rdy (p_rdy)
`ifdef INDARB_STATS_EN
    ,
    .stat_clear   (st_clear),
    .stat_count   (st_count)
`endif
  );

  int tests  = 0;
  int failed = 0;

  // Reference model: a set of occupied slots, their contents, and the next
  // source to be favoured.
  bit               m_valid [NREQ];
  logic [WIDTH-1:0] m_slot  [NREQ];
  int               m_ptr;
  logic [15:0]      m_cnt   [NREQ];

  function automatic int m_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (m_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_valid[i] = 1'b0;
      m_slot[i]  = '0;
      m_cnt[i]   = '0;
    end
    m_ptr = 0;
  endfunction

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] get_msg(input int i);
    return in_v[i*WIDTH +: WIDTH];
  endfunction

  task automatic set_msg(input int i, input logic [WIDTH-1:0] m);
    in_v[i*WIDTH +: WIDTH] = m;
  endtask

  // Check all outputs against the model mid-cycle, then advance one edge.
  task automatic cycle();
    int               g;
    bit               fire;
    logic [NREQ-1:0]  er;
    logic [WIDTH-1:0] ed;
    #3;
    g = m_grant();
    for (int i = 0; i < NREQ; i++) er[i] = nRST && !m_valid[i];
    ed = (g >= 0) ? m_slot[g] : '0;
    chk("rdy",  WIDTH'(in_rdy), WIDTH'(er));
    chk("ena",  WIDTH'(p_ena),  WIDTH'(g >= 0 && p_rdy));
    chk("data", p_v, ed);
    chk("src",  WIDTH'(p_src),  (g >= 0) ? WIDTH'(g) : '0);
`ifdef INDARB_STATS_EN
    chk("count", WIDTH'(st_count), WIDTH'({m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]}));
`endif
    @(posedge CLK);
    if (!nRST) begin
      m_reset();
    end else begin
      fire = (g >= 0) && p_rdy;
      for (int i = 0; i < NREQ; i++) begin
        if (in_ena[i] && !m_valid[i]) begin
          m_valid[i] = 1'b1;
          m_slot[i]  = get_msg(i);
        end
      end
`ifdef INDARB_STATS_EN
      if (st_clear) begin
        for (int i = 0; i < NREQ; i++) m_cnt[i] = '0;
      end else if (fire) begin
        m_cnt[g] = m_cnt[g] + 16'd1;
      end
`endif
      if (fire) begin
        m_valid[g] = 1'b0;
        m_ptr      = (g + 1) % NREQ;
      end
    end
    #1;
  endtask

  task automatic fill(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) set_msg(i, {$urandom, $urandom, $urandom});
    end
    in_ena = mask;
    cycle();
    in_ena = '0;
  endtask

  initial begin
    logic [WIDTH-1:0] m0;
    nRST   = 1'b0;
    in_ena = '0;
    in_v   = '0;
    p_rdy  = 1'b1;
`ifdef INDARB_STATS_EN
    st_clear = 1'b0;
`endif
    m_reset();
    #1;
    chk("reset_ena",  WIDTH'(p_ena),  '0);
    chk("reset_rdy",  WIDTH'(in_rdy), '0);
    chk("reset_data", p_v,            '0);
    chk("reset_src",  WIDTH'(p_src),  '0);
    cycle();
    cycle();
    nRST = 1'b1;
    cycle();
    chk("post_reset_rdy", WIDTH'(in_rdy), WIDTH'(4'hF));

    // Single source: beat appears the cycle after the accepting edge.
    set_msg(2, {32'h55, 32'd7, 32'd1});
    in_ena = 4'b0100;
    cycle();
    in_ena = '0;
    chk("single_ena",  WIDTH'(p_ena), WIDTH'(1));
    chk("single_data", p_v, {32'h55, 32'd7, 32'd1});
    chk("single_src",  WIDTH'(p_src), WIDTH'(2));
    chk("single_rdy_low", WIDTH'(in_rdy[2]), '0);
    cycle();
    chk("single_rdy_back", WIDTH'(in_rdy[2]), WIDTH'(1));
    chk("single_idle", WIDTH'(p_ena), '0);

    // Bring the pointer back to 0 with a beat from source 3.
    fill(4'b1000);
    cycle();

    // Round robin from pointer 0, twice, then sources 1 and 3 from pointer 2.
    for (int rep = 0; rep < 2; rep++) begin
      fill(4'hF);
      for (int s = 0; s < NREQ; s++) begin
        chk("rr_src", WIDTH'(p_src), WIDTH'(s));
        chk("rr_ena", WIDTH'(p_ena), WIDTH'(1));
        cycle();
      end
    end
    fill(4'b0010);
    cycle();
    fill(4'b1010);
    chk("rr_ptr2_first",  WIDTH'(p_src), WIDTH'(3));
    cycle();
    chk("rr_ptr2_second", WIDTH'(p_src), WIDTH'(1));
    cycle();

    // Backpressure: output held and stable, then released in order.
    p_rdy = 1'b0;
    fill(4'b0011);
    m0 = get_msg(0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_ena",  WIDTH'(p_ena), '0);
      chk("bp_src",  WIDTH'(p_src), '0);
      chk("bp_data", p_v, m0);
      cycle();
    end
    p_rdy = 1'b1;
    chk("bp_rel0", WIDTH'(p_src), '0);
    chk("bp_rel0_data", p_v, m0);
    cycle();
    chk("bp_rel1", WIDTH'(p_src), WIDTH'(1));
    cycle();
    chk("bp_done", WIDTH'(p_ena), '0);

    // Source 0 refills whenever free; source 1 enqueues as source 0 drains.
    for (int k = 0; k < 10; k++) begin
      set_msg(0, {$urandom, $urandom, $urandom});
      set_msg(1, {$urandom, $urandom, $urandom});
      in_ena[0] = !m_valid[0];
      in_ena[1] = m_valid[0] && !m_valid[1];
      if (k >= 1) chk("gapfree", WIDTH'(p_ena), WIDTH'(1));
      cycle();
    end
    in_ena = '0;
    cycle();
    cycle();

    // Randomised traffic with random backpressure.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < NREQ; i++) set_msg(i, {$urandom, $urandom, $urandom});
      in_ena = NREQ'($urandom);
      p_rdy  = ($urandom % 4) != 0;
      cycle();
    end
    in_ena = '0;
    p_rdy  = 1'b1;
    repeat (4) cycle();

    // Reset mid-traffic with three slots full.
    p_rdy = 1'b0;
    fill(4'b0111);
    p_rdy = 1'b1;
    nRST  = 1'b0;
    #1;
    chk("midrst_ena", WIDTH'(p_ena),  '0);
    chk("midrst_rdy", WIDTH'(in_rdy), '0);
    m_reset();
    cycle();
    cycle();
    nRST = 1'b1;
    cycle();
    chk("midrst_rdy_back", WIDTH'(in_rdy), WIDTH'(4'hF));
    chk("midrst_nostale",  WIDTH'(p_ena),  '0);
    cycle();

`ifdef INDARB_STATS_EN
    // Counter wrap and clear-wins-over-drain.
    dut.cnt_q[3] = 16'hFFFE;
    m_cnt[3]     = 16'hFFFE;
    fill(4'b1000);
    cycle();
    chk("cnt_ffff", WIDTH'(st_count[63:48]), WIDTH'(16'hFFFF));
    fill(4'b1000);
    cycle();
    chk("cnt_wrap", WIDTH'(st_count[63:48]), '0);
    fill(4'b1000);
    st_clear = 1'b1;
    cycle();
    st_clear = 1'b0;
    chk("cnt_clear_wins", WIDTH'(st_count[63:48]), '0);
    cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
